// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock divider with phase, sync and glitch-free start/stop
module clk_div_gen #(
    parameter int CH    = 4,
    parameter int DIV_W = 8,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    run
);

    logic [DIV_W-1:0] cnt       [CH];
    logic [DIV_W-1:0] div_act   [CH];
    logic [DIV_W-1:0] phase_act [CH];
    logic [DIV_W-1:0] sh_div    [CH];
    logic [DIV_W-1:0] sh_phase  [CH];
    logic [CH-1:0]    sh_en;
    logic [CH-1:0]    pending;

    logic [DIV_W-1:0] cnt_n       [CH];
    logic [DIV_W-1:0] div_n       [CH];
    logic [DIV_W-1:0] phase_n     [CH];
    logic [DIV_W-1:0] sh_div_n    [CH];
    logic [DIV_W-1:0] sh_phase_n  [CH];
    logic [CH-1:0]    sh_en_n;
    logic [CH-1:0]    pending_n;
    logic [CH-1:0]    run_n;
    logic [CH-1:0]    clk_n;
    logic [CH-1:0]    tick_n;

    logic             xfer;
    logic [DIV_W-1:0] cfg_div_eff;
    logic [DIV_W-1:0] cfg_phase_eff;

    // Selects beyond CH (non power-of-two CH) are always ready and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        if (32'(cfg_ch) < CH) begin
            cfg_ready = ~pending[cfg_ch];
        end
    end

    assign xfer          = cfg_valid && cfg_ready;
    assign cfg_div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign cfg_phase_eff = (cfg_phase <= cfg_div_eff) ? cfg_phase : '0;

    always_comb begin
        for (int i = 0; i < CH; i++) begin : g_next
            logic             sel;
            logic             pend_eff;
            logic             wrap;
            logic             apply;
            logic [DIV_W-1:0] new_div;
            logic [DIV_W-1:0] new_phase;
            logic             new_en;
            logic [DIV_W:0]   half;

            sel       = xfer && (32'(cfg_ch) == i);
            pend_eff  = pending[i] | sel;
            new_div   = sel ? cfg_div_eff   : sh_div[i];
            new_phase = sel ? cfg_phase_eff : sh_phase[i];
            new_en    = sel ? cfg_en        : sh_en[i];
            wrap      = run[i] && (cnt[i] == div_act[i]);
            apply     = pend_eff && (!run[i] || wrap);

            sh_div_n[i]   = new_div;
            sh_phase_n[i] = new_phase;
            sh_en_n[i]    = new_en;
            pending_n[i]  = pend_eff;
            div_n[i]      = div_act[i];
            phase_n[i]    = phase_act[i];
            run_n[i]      = run[i];

            if (!run[i] || wrap) begin
                cnt_n[i] = '0;
            end else begin
                cnt_n[i] = cnt[i] + DIV_W'(1);
            end

            // A stopped channel starts at its phase; a running one restarts
            // the new period from zero so the boundary stays clean.
            if (apply) begin
                div_n[i]     = new_div;
                phase_n[i]   = new_phase;
                run_n[i]     = new_en;
                pending_n[i] = 1'b0;
                if (new_en && !run[i]) begin
                    cnt_n[i] = new_phase;
                end else begin
                    cnt_n[i] = '0;
                end
            end

            if (sync && run[i] && run_n[i]) begin
                cnt_n[i] = phase_n[i];
            end

            half      = ({1'b0, div_n[i]} + (DIV_W+1)'(2)) >> 1;
            clk_n[i]  = run_n[i] && ({1'b0, cnt_n[i]} < half);
            tick_n[i] = run_n[i] && (cnt_n[i] == div_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i]       <= '0;
                div_act[i]   <= DIV_W'(1);
                phase_act[i] <= '0;
                sh_div[i]    <= DIV_W'(1);
                sh_phase[i]  <= '0;
            end
            sh_en   <= '0;
            pending <= '0;
            run     <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            cnt       <= cnt_n;
            div_act   <= div_n;
            phase_act <= phase_n;
            sh_div    <= sh_div_n;
            sh_phase  <= sh_phase_n;
            sh_en     <= sh_en_n;
            pending   <= pending_n;
            run       <= run_n;
            clk_out   <= clk_n;
            tick      <= tick_n;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
module tb_clk_div_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       cfg_en;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic [3:0] run;

    int errors = 0;
    int checks = 0;

    clk_div_gen #(.CH(4), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .run       (run)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_phase = ph;
        cfg_en    = en;
        #1;
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
        #1;
    endtask

    logic [7:0] pat_clk;
    logic [7:0] pat_tick;
    logic [1:0] s_clk  [8];
    logic [1:0] s_tick [8];

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        cfg_phase = 8'd0; cfg_en = 1'b0; sync = 1'b0;

        // reset state
        repeat (3) begin
            step();
            chk("rst_clk_out", 32'(clk_out), 32'h0);
            chk("rst_tick", 32'(tick), 32'h0);
            chk("rst_run", 32'(run), 32'h0);
            chk("rst_ready", 32'(cfg_ready), 32'h1);
        end

        // stopped-channel start, P=4
        rst = 1'b0;
        cfg(2'd0, 8'd3, 8'd0, 1'b1);
        chk("s1_ready", 32'(cfg_ready), 32'h1);
        step(); idle();
        pat_clk  = 8'b00110011;
        pat_tick = 8'b10001000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk("s1_clk0", 32'(clk_out[0]), 32'(pat_clk[k]));
            chk("s1_tick0", 32'(tick[0]), 32'(pat_tick[k]));
            chk("s1_run0", 32'(run[0]), 32'h1);
        end

        // odd divide P=5 with phase 2
        cfg(2'd1, 8'd4, 8'd2, 1'b1);
        step(); idle();
        pat_clk  = 8'b00111001;
        pat_tick = 8'b00000100;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk("s2_clk1", 32'(clk_out[1]), 32'(pat_clk[k]));
            chk("s2_tick1", 32'(tick[1]), 32'(pat_tick[k]));
        end
        // stop ch1 on its boundary, then restart with an out-of-range phase
        cfg(2'd1, 8'd4, 8'd0, 1'b0);
        step(); idle();
        chk("s2_ready_pend", 32'(cfg_ready), 32'h0);
        chk("s2_run_pend", 32'(run[1]), 32'h1);
        step();
        chk("s2_tick_last", 32'(tick[1]), 32'h1);
        step();
        chk("s2_run_stop", 32'(run[1]), 32'h0);
        chk("s2_clk_stop", 32'(clk_out[1]), 32'h0);
        chk("s2_ready_free", 32'(cfg_ready), 32'h1);
        cfg(2'd1, 8'd4, 8'd9, 1'b1);
        step(); idle();
        pat_clk  = 8'b00000111;
        pat_tick = 8'b00010000;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk("s2_clamp_clk1", 32'(clk_out[1]), 32'(pat_clk[k]));
            chk("s2_clamp_tick1", 32'(tick[1]), 32'(pat_tick[k]));
            chk("s2_clamp_run1", 32'(run[1]), 32'h1);
        end

        // live reconfigure P=4 -> P=2, then glitch-free stop
        rst = 1'b1; step(); rst = 1'b0;
        cfg(2'd0, 8'd3, 8'd0, 1'b1);
        step(); idle();
        chk("s3_clk_c0", 32'(clk_out[0]), 32'h1);
        step();
        cfg(2'd0, 8'd1, 8'd0, 1'b1);
        step(); idle();
        chk("s3_ready_c2", 32'(cfg_ready), 32'h0);
        chk("s3_clk_c2", 32'(clk_out[0]), 32'h0);
        step();
        chk("s3_tick_c3", 32'(tick[0]), 32'h1);
        chk("s3_ready_c3", 32'(cfg_ready), 32'h0);
        step();
        chk("s3_clk_wrap", 32'(clk_out[0]), 32'h1);
        chk("s3_tick_wrap", 32'(tick[0]), 32'h0);
        chk("s3_ready_wrap", 32'(cfg_ready), 32'h1);
        step();
        chk("s3_clk_p2_1", 32'(clk_out[0]), 32'h0);
        chk("s3_tick_p2_1", 32'(tick[0]), 32'h1);
        step();
        chk("s3_clk_p2_0", 32'(clk_out[0]), 32'h1);
        cfg(2'd0, 8'd1, 8'd0, 1'b0);
        step(); idle();
        chk("s3_stop_pend_clk", 32'(clk_out[0]), 32'h0);
        chk("s3_stop_pend_run", 32'(run[0]), 32'h1);
        chk("s3_stop_pend_ready", 32'(cfg_ready), 32'h0);
        repeat (4) begin
            step();
            chk("s3_stopped_clk", 32'(clk_out[0]), 32'h0);
            chk("s3_stopped_run", 32'(run[0]), 32'h0);
            chk("s3_stopped_tick", 32'(tick[0]), 32'h0);
        end

        // sync alignment of P=4 and P=8 started 3 cycles apart
        rst = 1'b1; step(); rst = 1'b0;
        cfg(2'd0, 8'd3, 8'd0, 1'b1);
        step(); idle();
        step(); step();
        cfg(2'd1, 8'd7, 8'd0, 1'b1);
        step(); idle();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("s4_clk_sync", 32'(clk_out[1:0]), 32'h3);
        chk("s4_tick_sync", 32'(tick[1:0]), 32'h0);
        s_clk  = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11};
        s_tick = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        for (int k = 0; k < 8; k++) begin
            step();
            chk("s4_clk", 32'(clk_out[1:0]), 32'(s_clk[k]));
            chk("s4_tick", 32'(tick[1:0]), 32'(s_tick[k]));
        end

        // sync coinciding with a pending apply on ch2
        rst = 1'b1; step(); rst = 1'b0;
        cfg(2'd2, 8'd3, 8'd0, 1'b1);
        step();
        chk("s5_clk_c0", 32'(clk_out[2]), 32'h1);
        cfg(2'd2, 8'd5, 8'd3, 1'b1);
        step(); idle();
        step();
        step();
        chk("s5_tick_c3", 32'(tick[2]), 32'h1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("s5_clk_apply", 32'(clk_out[2]), 32'h0);
        chk("s5_tick_apply", 32'(tick[2]), 32'h0);
        chk("s5_run_apply", 32'(run[2]), 32'h1);
        chk("s5_ready_apply", 32'(cfg_ready), 32'h1);
        step();
        chk("s5_clk_c4", 32'(clk_out[2]), 32'h0);
        chk("s5_tick_c4", 32'(tick[2]), 32'h0);
        step();
        chk("s5_tick_c5", 32'(tick[2]), 32'h1);
        step();
        chk("s5_clk_c0b", 32'(clk_out[2]), 32'h1);

        // reset during a high phase with pending configs
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg(2'(c), 8'd7, 8'd0, 1'b1);
            step();
        end
        idle();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("s6_clk_all", 32'(clk_out), 32'hf);
        chk("s6_run_all", 32'(run), 32'hf);
        cfg(2'd0, 8'd1, 8'd0, 1'b1);
        step();
        cfg(2'd1, 8'd1, 8'd0, 1'b1);
        step(); idle();
        chk("s6_clk_high", 32'(clk_out), 32'hf);
        cfg_ch = 2'd0; #1;
        chk("s6_ready_pend", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        step();
        chk("s6_rst_clk", 32'(clk_out), 32'h0);
        chk("s6_rst_tick", 32'(tick), 32'h0);
        chk("s6_rst_run", 32'(run), 32'h0);
        chk("s6_rst_ready0", 32'(cfg_ready), 32'h1);
        cfg_ch = 2'd1; #1;
        chk("s6_rst_ready1", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        repeat (12) begin
            step();
            chk("s6_post_run", 32'(run), 32'h0);
            chk("s6_post_clk", 32'(clk_out), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
